// File: rtl/game_pkg.sv
// Shared command-byte constants, FSM state type and command decoder for uart_cmd_hold.
// The ECHO state only exists when UART_CMD_ECHO_EN is defined.
package game_pkg;

  localparam logic [7:0] CMD_UP      = 8'h77;  // 'w'
  localparam logic [7:0] CMD_DOWN    = 8'h73;  // 's'
  localparam logic [7:0] CMD_LEFT    = 8'h61;  // 'a'
  localparam logic [7:0] CMD_RIGHT   = 8'h64;  // 'd'
  localparam logic [7:0] CMD_ATTACK  = 8'h20;  // ' '
  localparam logic [7:0] CMD_RELEASE = 8'h78;  // 'x'
  localparam logic [7:0] CASE_BIT    = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef UART_CMD_ECHO_EN
    ST_ECHO   = 2'd2,
`endif
    ST_DECODE = 2'd1
  } state_t;

  typedef enum logic [2:0] {
    K_NONE    = 3'd0,
    K_UP      = 3'd1,
    K_DOWN    = 3'd2,
    K_LEFT    = 3'd3,
    K_RIGHT   = 3'd4,
    K_ATTACK  = 3'd5,
    K_RELEASE = 3'd6
  } cmd_kind_t;

  // Forcing bit 5 folds 'A'..'Z' onto 'a'..'z'; space is matched exactly so 0x00 is not taken as attack.
  function automatic cmd_kind_t decode_cmd(input logic [7:0] b);
    logic [7:0] lc;
    lc = b | CASE_BIT;
    if (b == CMD_ATTACK)        decode_cmd = K_ATTACK;
    else if (lc == CMD_UP)      decode_cmd = K_UP;
    else if (lc == CMD_DOWN)    decode_cmd = K_DOWN;
    else if (lc == CMD_LEFT)    decode_cmd = K_LEFT;
    else if (lc == CMD_RIGHT)   decode_cmd = K_RIGHT;
    else if (lc == CMD_RELEASE) decode_cmd = K_RELEASE;
    else                        decode_cmd = K_NONE;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Retriggerable hold timer: load starts a LENGTH-cycle hold, expired flags its last cycle.
// The count saturates at zero; load has priority over clear and over expiry.
module hold_timer #(
  parameter int unsigned LENGTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int unsigned W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [W-1:0] RELOAD = W'(LENGTH - 1);

  logic [W-1:0] count;
  logic         active;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= {W{1'b0}};
      active <= 1'b0;
    end else if (load) begin
      count  <= RELOAD;
      active <= 1'b1;
    end else if (clear) begin
      count  <= {W{1'b0}};
      active <= 1'b0;
    end else if (active) begin
      if (count == {W{1'b0}}) active <= 1'b0;
      else                    count  <= count - W'(1);
    end
  end

  assign expired = active && (count == {W{1'b0}});

endmodule

// File: rtl/uart_cmd_hold.sv
// UART keyboard command decoder driving held button levels for the hero controller.
// Define UART_CMD_ECHO_EN to echo each accepted command back through the transmit FIFO.
module uart_cmd_hold
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 10_000_000,
  parameter int unsigned ATTACK_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] tx_data,
  output logic       btn_up,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_attack,
  output logic [7:0] last_cmd
);

  state_t    state, next_state;
  logic [7:0] rx_byte;
  cmd_kind_t kind;
  cmd_kind_t pend_kind;
  logic      latch_en, decode_en, rd_next;
  logic      dir_load, atk_load, release_all;
  logic      dir_expired, atk_expired;
`ifdef UART_CMD_ECHO_EN
  logic      wr_next;
`endif

  assign kind = decode_cmd(rx_byte);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rd_next    = 1'b0;
    latch_en   = 1'b0;
    decode_en  = 1'b0;
`ifdef UART_CMD_ECHO_EN
    wr_next    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rx_empty) begin
          latch_en   = 1'b1;
          rd_next    = 1'b1;
          next_state = ST_DECODE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DECODE: begin
        decode_en = 1'b1;
`ifdef UART_CMD_ECHO_EN
        if (kind != K_NONE) next_state = ST_ECHO;
        else                next_state = ST_IDLE;
`else
        next_state = ST_IDLE;
`endif
      end
`ifdef UART_CMD_ECHO_EN
      ST_ECHO: begin
        if (!tx_full) begin
          wr_next    = 1'b1;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_ECHO;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Decode result is staged one cycle so the buttons change on the cycle after DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_uart   <= 1'b0;
      rx_byte   <= 8'h00;
      last_cmd  <= 8'h00;
      pend_kind <= K_NONE;
    end else begin
      rd_uart <= rd_next;
      if (latch_en) rx_byte <= rx_data;
      if (decode_en && (kind != K_NONE)) last_cmd <= rx_byte;
      pend_kind <= decode_en ? kind : K_NONE;
    end
  end

`ifdef UART_CMD_ECHO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_uart <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      wr_uart <= wr_next;
      if (wr_next) tx_data <= last_cmd;
    end
  end
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign wr_uart = 1'b0;
  assign tx_data = 8'h00;
`endif

  assign dir_load    = (pend_kind == K_UP) || (pend_kind == K_DOWN) ||
                       (pend_kind == K_LEFT) || (pend_kind == K_RIGHT);
  assign atk_load    = (pend_kind == K_ATTACK);
  assign release_all = (pend_kind == K_RELEASE);

  hold_timer #(.LENGTH(HOLD_CYCLES)) u_dir_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (dir_load),
    .clear   (release_all),
    .expired (dir_expired)
  );

  hold_timer #(.LENGTH(ATTACK_CYCLES)) u_atk_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (atk_load),
    .clear   (release_all),
    .expired (atk_expired)
  );

  // A new command outranks a same-cycle expiry, so auto-repeat never opens a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_up     <= 1'b0;
      btn_down   <= 1'b0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_attack <= 1'b0;
    end else begin
      if (dir_load) begin
        btn_up    <= (pend_kind == K_UP);
        btn_down  <= (pend_kind == K_DOWN);
        btn_left  <= (pend_kind == K_LEFT);
        btn_right <= (pend_kind == K_RIGHT);
      end else if (release_all || dir_expired) begin
        btn_up    <= 1'b0;
        btn_down  <= 1'b0;
        btn_left  <= 1'b0;
        btn_right <= 1'b0;
      end
      if (atk_load)                        btn_attack <= 1'b1;
      else if (release_all || atk_expired) btn_attack <= 1'b0;
    end
  end

endmodule

// File: doc/uart_cmd_hold.md
UART_CMD_HOLD -- requirements
Module: uart_cmd_hold

Interface
REQ-001 Parameter HOLD_CYCLES, default 10_000_000, sets how many clk cycles a direction output stays high after its last command byte (100 ms at 100 MHz).
REQ-002 Parameter ATTACK_CYCLES, default 1_000_000, sets the attack pulse length in clk cycles (10 ms, longer than one 150 Hz game tick).
REQ-003 clk  input  1  single clock domain, 100 MHz UART domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx_empty  input  1  receive FIFO empty flag; rx_data is valid whenever it is 0 (first-word-fall-through).
REQ-006 rx_data  input  8  received byte at the FIFO head.
REQ-007 rd_uart  output  1  one-cycle pop strobe to the receive FIFO.
REQ-008 tx_full  input  1  transmit FIFO full flag.
REQ-009 wr_uart  output  1  one-cycle push strobe to the transmit FIFO.
REQ-010 tx_data  output  8  echo byte.
REQ-011 btn_up, btn_down, btn_left, btn_right, btn_attack  output  1 each  held button levels toward the hero controller.
REQ-012 last_cmd  output  8  last accepted command byte, for the LEDs.

Function
REQ-013 FSM states: IDLE, DECODE, ECHO.
REQ-014 IDLE: when rx_empty=0, the block latches rx_data, drives rd_uart=1 for exactly the next cycle, and moves to DECODE.
REQ-015 rd_uart is never high on two consecutive cycles, and it is never asserted while rx_empty=1.
REQ-016 DECODE (one cycle) updates the outputs with a registered update that is visible on the cycle after DECODE.
  - Total latency is 3 clk cycles from the first clk edge that samples rx_empty=0 to the changed button output.
REQ-017 Command codes, both cases accepted:
  - 'w'/'W'=up, 's'/'S'=down, 'a'/'A'=left, 'd'/'D'=right.
  - 0x20 (space)=attack.
  - 'x'/'X'=release all.
  - All other bytes are popped and ignored: no output change, last_cmd unchanged.
REQ-018 A direction command sets its own button, clears the other three direction buttons, and reloads the hold counter to HOLD_CYCLES-1.
REQ-019 Repeating the same direction reloads the hold counter, so keyboard auto-repeat keeps the button held without a gap.
REQ-020 While any direction is held, the hold counter decrements once per cycle; when it reaches 0, all direction buttons clear.
REQ-021 Attack sets btn_attack and reloads the attack counter to ATTACK_CYCLES-1.
  - It does not affect the direction buttons.
  - btn_attack clears when the attack counter reaches 0.
REQ-022 Release clears all five buttons and zeroes both counters.
REQ-023 When a counter expires in the same cycle that a command for that counter is decoded, the new command wins: the button stays high and the counter reloads.
REQ-024 Counter widths are $clog2 of the respective parameter, with no wrap: each counter saturates at 0.
REQ-025 A valid command updates last_cmd to the raw received byte.
REQ-026 After DECODE the FSM goes to ECHO if echo is compiled in and the byte was a valid command; otherwise it returns to IDLE.

Reset
REQ-027 When rst=1 at a clk edge:
  - state becomes IDLE.
  - all buttons, rd_uart, wr_uart, tx_data, last_cmd and both counters become 0.
REQ-028 A reset during DECODE or ECHO abandons the byte with no echo; a byte already popped is lost.

Configuration
REQ-029 Macro UART_CMD_ECHO_EN defined:
  - ECHO waits while tx_full=1.
  - When tx_full=0, ECHO drives wr_uart=1 for one cycle with tx_data=last_cmd, then returns to IDLE.
  - rx bytes arriving during the wait stay in the FIFO.
REQ-030 Macro UART_CMD_ECHO_EN undefined: the ECHO state is absent, wr_uart and tx_data are tied to 0, and tx_full is ignored.

Structure
REQ-031 Shared package game_pkg holds:
  - the command byte constants (CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_ATTACK, CMD_RELEASE);
  - the FSM state typedef.
REQ-032 One sub-module, hold_timer, is instantiated twice (direction and attack): load input, expiry output, parameterised length.

Verification
REQ-033 The bench runs with HOLD_CYCLES=100 and ATTACK_CYCLES=10, and covers:
  - Stimulus: push 'w'. Required: rd_uart pulses once, btn_up=1 exactly 3 cycles after rx_empty falls, btn_up=0 exactly 100 cycles later.
  - Stimulus: push 'd' every 60 cycles, 5 times. Required: btn_right stays high continuously, then falls 100 cycles after the last update.
  - Stimulus: push 'a' then 'S' back-to-back. Required: btn_left clears when btn_down sets; never two direction buttons high at once; 'S' is accepted as down.
  - Stimulus: push ' ' while up is held. Required: btn_attack is high for 10 cycles and btn_up is unaffected. Stimulus: push 'x'. Required: all outputs 0.
  - Stimulus: push 0x41 ('A') then 0x7A ('z'). Required: left is set; 'z' is popped with no change and last_cmd stays 0x41.
  - Stimulus: echo compiled in, push 'w' with tx_full=1 for 20 cycles. Required: wr_uart is asserted once with tx_data=0x77, only after tx_full falls.
  - Stimulus: assert rst mid-ECHO. Required: no wr_uart, all outputs 0.
